cpu_bus_master: RTL and testbench

// - CPU-side initiator for the system bus that the address decoder observes. Turns

---
 rtl/bus_pkg.sv | 25 ++
 rtl/cpu_bus_master_if.sv | 31 +++
 rtl/bus_tstate_seq.sv | 39 +++
 rtl/cpu_bus_master.sv | 66 ++++++
 tb/tb_cpu_bus_master.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the CPU-side system bus: T-state encoding,
// bus widths, the reset address and the T-state successor function.
package bus_pkg;

  localparam int          BUS_ADDR_W     = 16;
  localparam int          BUS_DATA_W     = 8;
  localparam logic [15:0] BUS_RESET_ADDR = 16'h0000;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} bus_tstate_t;

  // T4 can chain straight into T1 so back-to-back M-cycles have no idle gap.
  function automatic bus_tstate_t next_tstate(input bus_tstate_t cur, input logic accept);
    bus_tstate_t nxt;
    case (cur)
      IDLE:    nxt = accept ? T1 : IDLE;
      T1:      nxt = T2;
      T2:      nxt = T3;
      T3:      nxt = T4;
      T4:      nxt = accept ? T1 : IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_bus_master_if.sv
// Request/response handshake plus the system-bus pins driven by cpu_bus_master.
interface cpu_bus_master_if import bus_pkg::*; #(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d_out;
  logic              d_oe;
  logic [DATA_W-1:0] d_in;
  logic              cpu_raw_rd;
  logic              cpu_wr_sync;

  modport master (
    input  req_valid, req_addr, req_we, req_wdata, d_in,
    output req_ready, rsp_valid, rsp_rdata, a, d_out, d_oe, cpu_raw_rd, cpu_wr_sync
  );

  modport slave (
    output req_valid, req_addr, req_we, req_wdata, d_in,
    input  req_ready, rsp_valid, rsp_rdata, a, d_out, d_oe, cpu_raw_rd, cpu_wr_sync
  );

endinterface

// File: rtl/bus_tstate_seq.sv
// T-state sequencer: state register and next-state logic, with registered
// one-hot flags for IDLE and T1..T4.
module bus_tstate_seq import bus_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  output logic is_idle,
  output logic is_t1,
  output logic is_t2,
  output logic is_t3,
  output logic is_t4
);

  bus_tstate_t state;
  bus_tstate_t state_next;

  assign state_next = next_tstate(state, accept);

  // Flags are registered from the next state so the strobe decode downstream
  // works on flops only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      is_idle <= 1'b1;
      is_t1   <= 1'b0;
      is_t2   <= 1'b0;
      is_t3   <= 1'b0;
      is_t4   <= 1'b0;
    end else begin
      state   <= state_next;
      is_idle <= (state_next == IDLE);
      is_t1   <= (state_next == T1);
      is_t2   <= (state_next == T2);
      is_t3   <= (state_next == T3);
      is_t4   <= (state_next == T4);
    end
  end

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side bus initiator: turns single-byte core requests into 4-T-state
// M-cycles on a/d with read and synchronous-write strobes for the decoder.
module cpu_bus_master import bus_pkg::*; #(
  parameter int                ADDR_W     = BUS_ADDR_W,
  parameter int                DATA_W     = BUS_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(BUS_RESET_ADDR),
  parameter int                CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  cpu_bus_master_if.master bus,
  output logic [CNT_W-1:0] mcycle_cnt
);

  logic accept;
  logic is_idle, is_t1, is_t2, is_t3, is_t4;
  logic we_q;

  // Ready is gated by reset so a request presented during reset is never taken.
  assign bus.req_ready = (is_idle || is_t4) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  bus_tstate_seq u_seq (
    .clk     (clk),
    .reset   (reset),
    .accept  (accept),
    .is_idle (is_idle),
    .is_t1   (is_t1),
    .is_t2   (is_t2),
    .is_t3   (is_t3),
    .is_t4   (is_t4)
  );

  // a only moves on entry to T1 and holds through IDLE, keeping the decoder
  // input glitch-free between M-cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.a         <= RESET_ADDR;
      bus.d_out     <= '0;
      bus.rsp_rdata <= '0;
      we_q          <= 1'b0;
      mcycle_cnt    <= '0;
    end else begin
      if (accept) begin
        bus.a <= bus.req_addr;
        we_q  <= bus.req_we;
        if (bus.req_we) begin
          bus.d_out <= bus.req_wdata;
        end
      end
      if (is_t3) begin
        bus.rsp_rdata <= we_q ? '0 : bus.d_in;
      end
      if (is_t4) begin
        mcycle_cnt <= mcycle_cnt + CNT_W'(1);
      end
    end
  end

  // All flags clear asynchronously on reset, so strobes and d_oe drop at once.
  assign bus.rsp_valid   = is_t4;
  assign bus.cpu_raw_rd  = !we_q && (is_t1 || is_t2 || is_t3 || is_t4);
  assign bus.cpu_wr_sync = we_q && is_t3;
  assign bus.d_oe        = we_q && (is_t2 || is_t3 || is_t4);

endmodule

// File: tb/tb_cpu_bus_master.sv
// Self-checking bench for cpu_bus_master: T-state reference model, response
// scoreboard, table-driven requests and hand-written reset/wrap sequences.
module tb_cpu_bus_master;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          gap;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    bit         b2b;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [15:0] cnt_main;
  logic [3:0]  cnt_small;

  cpu_bus_master_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  cpu_bus_master_if #(.ADDR_W(16), .DATA_W(8)) small_bus ();

  cpu_bus_master #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .mcycle_cnt (cnt_main)
  );

  // Narrow-counter copy sees the same traffic so the wrap is reachable quickly.
  cpu_bus_master #(.CNT_W(4)) dut_small (
    .clk        (clk),
    .reset      (reset),
    .bus        (small_bus.master),
    .mcycle_cnt (cnt_small)
  );

  assign small_bus.req_valid = bus.req_valid;
  assign small_bus.req_addr  = bus.req_addr;
  assign small_bus.req_we    = bus.req_we;
  assign small_bus.req_wdata = bus.req_wdata;
  assign small_bus.d_in      = bus.d_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   last_rsp_cyc = 0;
  sb_t  sb_q[$];
  sb_t  sb_e;
  vec_t vecs[6];

  logic [2:0]  m_phase;
  logic        m_we;
  logic [15:0] m_a;
  logic [7:0]  m_wdata;
  logic [7:0]  m_din;
  logic [15:0] m_cnt;
  logic [7:0]  cur_din;
  logic        exp_ready, exp_rd, exp_wr, exp_oe, exp_valid;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference T-state model: phase 0 is IDLE, 1..4 are T1..T4.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 3'd0;
      m_we    <= 1'b0;
      m_a     <= 16'h0000;
      m_wdata <= 8'h00;
      m_din   <= 8'h00;
      m_cnt   <= 16'h0000;
    end else begin
      if (m_phase == 3'd4) m_cnt <= m_cnt + 16'd1;
      if (bus.req_valid && (m_phase == 3'd0 || m_phase == 3'd4)) begin
        m_phase <= 3'd1;
        m_a     <= bus.req_addr;
        m_we    <= bus.req_we;
        m_din   <= cur_din;
        if (bus.req_we) m_wdata <= bus.req_wdata;
      end else if (m_phase == 3'd4) begin
        m_phase <= 3'd0;
      end else if (m_phase != 3'd0) begin
        m_phase <= m_phase + 3'd1;
      end
    end
  end

  // Read data is only meaningful in T3; junk elsewhere exposes a wrong sample edge.
  always @(negedge clk) begin
    bus.d_in = (m_phase == 3'd3) ? m_din : 8'($urandom);
  end

  always @(negedge clk) begin
    exp_ready = (m_phase == 3'd0 || m_phase == 3'd4) && !reset;
    exp_rd    = (m_phase != 3'd0) && !m_we;
    exp_wr    = (m_phase == 3'd3) && m_we;
    exp_oe    = (m_phase >= 3'd2) && m_we;
    exp_valid = (m_phase == 3'd4);
    check_output("req_ready",   32'(bus.req_ready),   32'(exp_ready));
    check_output("cpu_raw_rd",  32'(bus.cpu_raw_rd),  32'(exp_rd));
    check_output("cpu_wr_sync", 32'(bus.cpu_wr_sync), 32'(exp_wr));
    check_output("d_oe",        32'(bus.d_oe),        32'(exp_oe));
    check_output("rsp_valid",   32'(bus.rsp_valid),   32'(exp_valid));
    check_output("a",           32'(bus.a),           32'(m_a));
    check_output("mcycle_cnt",  32'(cnt_main),        32'(m_cnt));
    check_output("small_cnt",   32'(cnt_small),       32'(m_cnt[3:0]));
    check_output("small_bus",
                 32'({small_bus.req_ready, small_bus.cpu_raw_rd, small_bus.cpu_wr_sync,
                      small_bus.d_oe, small_bus.rsp_valid, small_bus.a}),
                 32'({exp_ready, exp_rd, exp_wr, exp_oe, exp_valid, m_a}));
    if (m_we && m_phase != 3'd0) begin
      check_output("d_out",       32'(bus.d_out),       32'(m_wdata));
      check_output("small_d_out", 32'(small_bus.d_out), 32'(m_wdata));
    end
    if (reset) begin
      check_output("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    end
    if (bus.rsp_valid) begin
      if (sb_q.size() == 0) begin
        check_output("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
      end else begin
        sb_e = sb_q.pop_front();
        check_output("rsp_rdata",       32'(bus.rsp_rdata),       32'(sb_e.rdata));
        check_output("small_rsp_rdata", 32'(small_bus.rsp_rdata), 32'(sb_e.rdata));
        if (sb_e.b2b) check_output("b2b_spacing", 32'(cyc - last_rsp_cyc), 32'd4);
      end
      last_rsp_cyc = cyc;
    end
  end

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic apply_stimulus(input logic [15:0] addr, input logic we, input logic [7:0] wdata,
                                input logic [7:0] din, input bit b2b);
    sb_t e;
    int  waited;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    cur_din       = din;
    e.rdata = we ? 8'h00 : din;
    e.b2b   = b2b;
    sb_q.push_back(e);
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output("accept_wait", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'($urandom);
    bus.req_we    = 1'($urandom);
    bus.req_wdata = 8'($urandom);
  endtask

  initial begin
    int gap;
    vecs[0] = '{16'hFF0F, 1'b0, 8'h00, 8'hE1, 0};
    vecs[1] = '{16'hFF50, 1'b1, 8'h01, 8'h00, 6};
    vecs[2] = '{16'hC000, 1'b0, 8'h00, 8'h3C, 6};
    vecs[3] = '{16'hFF80, 1'b1, 8'h5A, 8'h00, 0};
    vecs[4] = '{16'h8001, 1'b0, 8'h00, 8'hA5, 0};
    vecs[5] = '{16'h0000, 1'b1, 8'hFF, 8'h00, 0};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h1234;
    bus.req_we    = 1'b0;
    bus.req_wdata = 8'h00;
    cur_din       = 8'h00;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    repeat (10) @(negedge clk);
    check_output("idle_a",    32'(bus.a),          32'h0000);
    check_output("idle_cnt",  32'(cnt_main),       32'h0);
    check_output("idle_strb", 32'({bus.cpu_raw_rd, bus.cpu_wr_sync, bus.d_oe}), 32'h0);

    for (int i = 0; i < 6; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      apply_stimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].din,
                     (vecs[i].gap == 0) && (i > 0));
    end
    repeat (6) @(negedge clk);

    // Abort a write in T2: strobes must fall without waiting for a clock.
    apply_stimulus(16'hFF90, 1'b1, 8'hAA, 8'h00, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    sb_q.delete();
    #1;
    check_output("abort_wr_sync", 32'(bus.cpu_wr_sync), 32'h0);
    check_output("abort_d_oe",    32'(bus.d_oe),        32'h0);
    check_output("abort_rsp",     32'(bus.rsp_valid),   32'h0);
    check_output("abort_a",       32'(bus.a),           32'h0000);
    check_output("abort_ready",   32'(bus.req_ready),   32'h0);
    bus.req_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    apply_stimulus(16'h4000, 1'b0, 8'h00, 8'h77, 1'b0);

    for (int i = 0; i < 20; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? 6 : 0;
      repeat (gap) @(negedge clk);
      apply_stimulus(16'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), gap == 0);
    end
    repeat (8) @(negedge clk);

    check_output("sb_drained",  32'(sb_q.size()), 32'h0);
    check_output("final_cnt",   32'(cnt_main),    32'd21);
    check_output("small_wrap",  32'(cnt_small),   32'd5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
